// File: rtl/conv_tile_ctrl.sv
// conv_tile_ctrl -- tile sequencer for one convolution layer.
//
// Walks a num_rows x num_cols grid of tiles in row-major order. For each tile it
// issues a one-cycle tile_start pulse to the systolic array. It then waits for
// tile_done before moving on to the next tile. start and done are level outputs
// that frame the layer for the downstream conv cycle counter.
//
// Optional feature: define CONV_CTRL_TIMEOUT_EN to add a 16-bit WAIT watchdog.
// When the watchdog expires it sets the sticky timeout_err flag and ends the
// layer early. Without the macro, timeout_err is tied to 0.
//
// Ports:
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   go           start a layer (sampled in IDLE only)
//   num_rows     tile rows, latched when go is accepted
//   num_cols     tile columns, latched when go is accepted
//   tile_done    tile-complete pulse from the array (honoured in WAIT only)
//   ack          consumer acknowledge of done (honoured in FINISH only)
//   start        high in every state except IDLE
//   done         high in FINISH until ack
//   tile_start   one-cycle tile launch pulse
//   row_idx      current tile row
//   col_idx      current tile column
//   tiles_cnt    tiles completed in this layer
//   timeout_err  sticky watchdog flag
module conv_tile_ctrl #(
    parameter int IDX_W = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 go,
    input  logic [IDX_W-1:0]     num_rows,
    input  logic [IDX_W-1:0]     num_cols,
    input  logic                 tile_done,
    input  logic                 ack,
    output logic                 start,
    output logic                 done,
    output logic                 tile_start,
    output logic [IDX_W-1:0]     row_idx,
    output logic [IDX_W-1:0]     col_idx,
    output logic [2*IDX_W-1:0]   tiles_cnt,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rows_q, rows_d;
    logic [IDX_W-1:0]   cols_q, cols_d;
    logic [IDX_W-1:0]   row_q, row_d;
    logic [IDX_W-1:0]   col_q, col_d;
    logic [2*IDX_W-1:0] cnt_q, cnt_d;
    logic               last_col, last_row;

`ifdef CONV_CTRL_TIMEOUT_EN
    logic [15:0]        wdog_q, wdog_d;
    logic               terr_q, terr_d;
`endif

    // Dimensions are known to be non-zero whenever these are used (in NEXT).
    assign last_col = (col_q == cols_q - IDX_W'(1));
    assign last_row = (row_q == rows_q - IDX_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CONV_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdog_q <= '0;
            terr_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            terr_q <= terr_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
`ifdef CONV_CTRL_TIMEOUT_EN
        wdog_d  = wdog_q;
        terr_d  = terr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    rows_d = num_rows;
                    cols_d = num_cols;
                    row_d  = '0;
                    col_d  = '0;
                    cnt_d  = '0;
`ifdef CONV_CTRL_TIMEOUT_EN
                    terr_d = 1'b0;
`endif
                    // An empty grid skips straight to FINISH.
                    state_d = ((num_rows == '0) || (num_cols == '0)) ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
`ifdef CONV_CTRL_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            S_WAIT: begin
                if (tile_done) begin
                    state_d = S_NEXT;
                    cnt_d   = cnt_q + (2*IDX_W)'(1);
                end
`ifdef CONV_CTRL_TIMEOUT_EN
                // The edge that would take the watchdog to 16'hFFFF is the expiry.
                else if (wdog_q == 16'hFFFE) begin
                    wdog_d  = 16'hFFFF;
                    terr_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    wdog_d  = wdog_q + 16'd1;
                end
`endif
            end
            S_NEXT: begin
                if (last_row && last_col) begin
                    // Leave the indices at the last tile.
                    state_d = S_FINISH;
                end else begin
                    state_d = S_LOAD;
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + IDX_W'(1);
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
            end
            S_FINISH: begin
                // A go arriving together with ack is dropped: the block returns to IDLE only.
                if (ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign start      = (state_q != S_IDLE);
    assign done       = (state_q == S_FINISH);
    assign tile_start = (state_q == S_LOAD);
    assign row_idx    = row_q;
    assign col_idx    = col_q;
    assign tiles_cnt  = cnt_q;
`ifdef CONV_CTRL_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_tile_ctrl.sv
// Directed bench for conv_tile_ctrl. Inputs change 1 ns after a rising edge,
// and outputs are checked at that same point.
module tb_conv_tile_ctrl;

    localparam int IDX_W = 8;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               go = 1'b0;
    logic [IDX_W-1:0]   num_rows = '0;
    logic [IDX_W-1:0]   num_cols = '0;
    logic               tile_done = 1'b0;
    logic               ack = 1'b0;
    logic               start, done, tile_start, timeout_err;
    logic [IDX_W-1:0]   row_idx, col_idx;
    logic [2*IDX_W-1:0] tiles_cnt;

    int n_cmp = 0;
    int n_err = 0;

    conv_tile_ctrl #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rstn(rstn), .go(go), .num_rows(num_rows), .num_cols(num_cols),
        .tile_done(tile_done), .ack(ack), .start(start), .done(done),
        .tile_start(tile_start), .row_idx(row_idx), .col_idx(col_idx),
        .tiles_cnt(tiles_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered while the tile is in LOAD. Returns one edge after NEXT, which is
    // LOAD of the following tile or FINISH. When inj is set, tile_done is pulsed
    // in LOAD, and go and ack are pulsed in WAIT; all three must be ignored.
    task automatic run_tile(input int r, input int c, input int n, input bit inj);
        chk($sformatf("t%0d tile_start", n), 32'(tile_start), 32'd1);
        chk($sformatf("t%0d row", n), 32'(row_idx), 32'(r));
        chk($sformatf("t%0d col", n), 32'(col_idx), 32'(c));
        chk($sformatf("t%0d start", n), 32'(start), 32'd1);
        chk($sformatf("t%0d done", n), 32'(done), 32'd0);
        tile_done = inj;
        step();                                  // WAIT
        tile_done = 1'b0;
        chk($sformatf("t%0d wait pulse", n), 32'(tile_start), 32'd0);
        go = inj; ack = inj;
        step();
        go = 1'b0; ack = 1'b0;
        chk($sformatf("t%0d wait hold", n), {30'd0, tile_start, done}, 32'd0);
        step();
        chk($sformatf("t%0d wait cnt", n), 32'(tiles_cnt), 32'(n - 1));
        tile_done = 1'b1;                        // sampled four edges after tile_start
        step();                                  // NEXT
        tile_done = 1'b0;
        chk($sformatf("t%0d cnt", n), 32'(tiles_cnt), 32'(n));
        chk($sformatf("t%0d next pulse", n), 32'(tile_start), 32'd0);
        step();
        $display("tile %0d at (%0d,%0d) inj=%0d cnt=%0d", n, r, c, inj, tiles_cnt);
    endtask

    initial begin
        // Reset state
        step();
        chk("rst outputs", {25'd0, start, done, tile_start, timeout_err, 3'd0}, 32'd0);
        chk("rst row", 32'(row_idx), 32'd0);
        chk("rst col", 32'(col_idx), 32'd0);
        chk("rst cnt", 32'(tiles_cnt), 32'd0);
        rstn = 1'b1;
        step();
        chk("idle start", 32'(start), 32'd0);

        // 2x3 layer with ignored go, ack and tile_done injected on tile 1
        num_rows = 8'd2; num_cols = 8'd3; go = 1'b1;
        step();
        go = 1'b0;
        for (int t = 0; t < 6; t++) run_tile(t / 3, t % 3, t + 1, t == 1);
        chk("A done", 32'(done), 32'd1);
        chk("A cnt", 32'(tiles_cnt), 32'd6);
        chk("A last row", 32'(row_idx), 32'd1);
        chk("A last col", 32'(col_idx), 32'd2);
        chk("A fin pulse", 32'(tile_start), 32'd0);
        chk("A terr", 32'(timeout_err), 32'd0);

        // FINISH holds without ack
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold done", 32'(done), 32'd1);
            chk("hold start", 32'(start), 32'd1);
        end
        $display("finish held 10 cycles");
        ack = 1'b1; go = 1'b1;                   // go together with ack must not start a layer
        step();
        ack = 1'b0; go = 1'b0;
        chk("ack done", 32'(done), 32'd0);
        chk("ack start", 32'(start), 32'd0);
        step();
        chk("no restart", {30'd0, start, tile_start}, 32'd0);
        $display("ack returned to idle");

        // Zero-row layer
        num_rows = 8'd0; num_cols = 8'd5; go = 1'b1;
        step();
        go = 1'b0;
        chk("B done", 32'(done), 32'd1);
        chk("B start", 32'(start), 32'd1);
        chk("B pulse", 32'(tile_start), 32'd0);
        chk("B cnt", 32'(tiles_cnt), 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("B ack", 32'(done), 32'd0);
        $display("zero-row layer finished");

        // 2x2 layer aborted by reset during the third tile
        num_rows = 8'd2; num_cols = 8'd2; go = 1'b1;
        step();
        go = 1'b0;
        run_tile(0, 0, 1, 1'b0);
        run_tile(0, 1, 2, 1'b0);
        chk("C t3 pulse", 32'(tile_start), 32'd1);
        chk("C t3 row", 32'(row_idx), 32'd1);
        step();                                  // third tile in WAIT
        #2 rstn = 1'b0;
        #1;
        chk("C async outs", {28'd0, start, done, tile_start, timeout_err}, 32'd0);
        chk("C async row", 32'(row_idx), 32'd0);
        chk("C async col", 32'(col_idx), 32'd0);
        chk("C async cnt", 32'(tiles_cnt), 32'd0);
        step();
        rstn = 1'b1; go = 1'b1;
        step();
        go = 1'b0;
        for (int t = 0; t < 4; t++) run_tile(t / 2, t % 2, t + 1, 1'b0);
        chk("C done", 32'(done), 32'd1);
        chk("C cnt", 32'(tiles_cnt), 32'd4);
        ack = 1'b1;
        step();
        ack = 1'b0;
        $display("reset abort and restart complete");

`ifdef CONV_CTRL_TIMEOUT_EN
        // Watchdog expiry with tile_done withheld
        num_rows = 8'd1; num_cols = 8'd1; go = 1'b1;
        step();
        go = 1'b0;
        chk("D pulse", 32'(tile_start), 32'd1);
        step();                                  // first WAIT cycle
        repeat (65534) step();
        chk("D pre done", 32'(done), 32'd0);
        chk("D pre terr", 32'(timeout_err), 32'd0);
        step();
        chk("D done", 32'(done), 32'd1);
        chk("D terr", 32'(timeout_err), 32'd1);
        chk("D cnt", 32'(tiles_cnt), 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("D sticky", 32'(timeout_err), 32'd1);
        go = 1'b1;
        step();
        go = 1'b0;
        chk("D cleared", 32'(timeout_err), 32'd0);
        run_tile(0, 0, 1, 1'b0);
        chk("D2 done", 32'(done), 32'd1);
        $display("watchdog timeout checked");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
